bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative double-dabble (shift-add-3).
- Sits directly upstream of the 3-digit display multiplexer: supplies the unit, ten and hundred BCD digits that the digit-select state machine scans.
- Output digits are double-buffered and change only on conversion completion, so the display never shows a partial result.

---
 rtl/bin2bcd_seq.sv | 120 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter feeding a 3-digit display scanner.
// Latency W+1 cycles from accepting edge; start is ignored while busy, digits hold between conversions.
module bin2bcd_seq #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [3:0]   bcd_u,
    output logic [3:0]   bcd_d,
    output logic [3:0]   bcd_c,
    output logic         ovf
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [11:0]   acc;
    logic [11:0]   acc_adj;
    logic [11:0]   acc_shift;
    logic [W-1:0]  sh;
    logic [CW-1:0] cnt;
    logic          ovf_pend;
    logic [10:0]   bin_ext;
    logic          load;
    logic          shift_en;
    logic          finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CW'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        load     = (state == S_IDLE) && start;
        shift_en = (state == S_SHIFT);
        finish   = (state == S_DONE);
    end

    // Add-3 correction on all nibbles happens before the shift of the same edge.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        acc_shift = (acc_adj << 1) | 12'(sh[W-1]);
        bin_ext   = 11'(bin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            sh       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else if (load) begin
            acc      <= '0;
            sh       <= bin;
            cnt      <= CW'(W);
            ovf_pend <= (bin_ext > 11'd999);
        end else if (shift_en) begin
            acc <= acc_shift;
            sh  <= sh << 1;
            cnt <= cnt - 1'b1;
        end
    end

    // Display-facing registers only change on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            bcd_u <= 4'd0;
            bcd_d <= 4'd0;
            bcd_c <= 4'd0;
            ovf   <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                if (ovf_pend) begin
                    bcd_c <= 4'd9;
                    bcd_d <= 4'd9;
                    bcd_u <= 4'd9;
                    ovf   <= 1'b1;
                end else begin
                    bcd_c <= acc[11:8];
                    bcd_d <= acc[7:4];
                    bcd_u <= acc[3:0];
                    ovf   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: table of values plus hand-written multi-cycle sequences.
module tb_bin2bcd_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bin = '0;
    logic       busy, done, ovf;
    logic [3:0] bcd_u, bcd_d, bcd_c;

    int n_cmp = 0;
    int n_err = 0;
    int cur_c = 0, cur_d = 0, cur_u = 0;

    typedef struct {
        int b;
        int c;
        int d;
        int u;
        int o;
    } vec_t;

    vec_t vecs[7];

    bin2bcd_seq #(.W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd_u (bcd_u),
        .bcd_d (bcd_d),
        .bcd_c (bcd_c),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one conversion, optionally pulsing start at cycles p1/p2 of it; returns done latency.
    task automatic run_conv(input int b, input int p1, input int p2, output int lat, output int stable);
        bin   = b[9:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        bin   = 10'd456;
        lat    = -1;
        stable = 1;
        chk("busy_after_accept", int'(busy), 1);
        for (int i = 1; i <= 20; i++) begin
            start = (i == p1 || i == p2);
            tick();
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (int'(bcd_c) != cur_c || int'(bcd_d) != cur_d || int'(bcd_u) != cur_u)
                stable = 0;
        end
    endtask

    task automatic check_result(input string tag, input int c, input int d, input int u, input int o,
                                input int lat, input int stable);
        chk({tag, "_latency"}, lat, 11);
        chk({tag, "_stable"}, stable, 1);
        chk({tag, "_c"}, int'(bcd_c), c);
        chk({tag, "_d"}, int'(bcd_d), d);
        chk({tag, "_u"}, int'(bcd_u), u);
        chk({tag, "_ovf"}, int'(ovf), o);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        cur_c = c;
        cur_d = d;
        cur_u = u;
        tick();
        chk({tag, "_done_width"}, int'(done), 0);
    endtask

    initial begin
        int lat, stable, ndone, t1, t2;
        int c1, d1, u1, c2, d2, u2;

        vecs[0] = '{b: 0,    c: 0, d: 0, u: 0, o: 0};
        vecs[1] = '{b: 255,  c: 2, d: 5, u: 5, o: 0};
        vecs[2] = '{b: 999,  c: 9, d: 9, u: 9, o: 0};
        vecs[3] = '{b: 407,  c: 4, d: 0, u: 7, o: 0};
        vecs[4] = '{b: 1000, c: 9, d: 9, u: 9, o: 1};
        vecs[5] = '{b: 1023, c: 9, d: 9, u: 9, o: 1};
        vecs[6] = '{b: 5,    c: 0, d: 0, u: 5, o: 0};

        #12;
        rst_n = 1'b1;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_digits", {int'(bcd_c), int'(bcd_d), int'(bcd_u)} != 0 ? 1 : 0, 0);
        chk("rst_ovf", int'(ovf), 0);

        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].b, -1, -1, lat, stable);
            check_result($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].u, vecs[i].o, lat, stable);
        end

        // bin is changed to 456 right after acceptance inside run_conv.
        run_conv(123, -1, -1, lat, stable);
        check_result("bin_change", 1, 2, 3, 0, lat, stable);

        run_conv(789, 3, 10, lat, stable);
        check_result("start_busy", 7, 8, 9, 0, lat, stable);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("start_busy_no_extra_done", ndone, 0);
        chk("start_busy_idle", int'(busy), 0);

        bin   = 10'd321;
        start = 1'b1;
        tick();
        bin = 10'd654;
        t1 = -1;
        t2 = -1;
        c1 = 0; d1 = 0; u1 = 0; c2 = 0; d2 = 0; u2 = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 12) start = 1'b0;
            if (done && t1 < 0) begin
                t1 = i; c1 = int'(bcd_c); d1 = int'(bcd_d); u1 = int'(bcd_u);
            end else if (done && t2 < 0) begin
                t2 = i; c2 = int'(bcd_c); d2 = int'(bcd_d); u2 = int'(bcd_u);
            end
        end
        chk("b2b_first_latency", t1, 11);
        chk("b2b_spacing", t2 - t1, 12);
        chk("b2b_first_value", c1 * 100 + d1 * 10 + u1, 321);
        chk("b2b_second_value", c2 * 100 + d2 * 10 + u2, 654);

        bin   = 10'd777;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_c", int'(bcd_c), 0);
        chk("midrst_d", int'(bcd_d), 0);
        chk("midrst_u", int'(bcd_u), 0);
        chk("midrst_ovf", int'(ovf), 0);
        #2;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("midrst_no_done_after_release", ndone, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
